// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - stall/flush sequencer with a shadow register scoreboard for the 5-stage pipeline
// Condition priority: data-memory busy, then taken branch, then RAW hazard, then issue.
module hazard_stall_controller #(
  parameter int CNT_W     = 32,
  parameter bit WB_BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      id_IR,
  input  logic             id_valid,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic             flush_id,
  output logic             freeze,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DSTALL = 2'd1;
  localparam logic [1:0] MSTALL = 2'd2;
  localparam logic [1:0] FLUSH  = 2'd3;

  localparam logic [5:0] OP_MOV  = 6'd1;
  localparam logic [5:0] OP_LD   = 6'd2;
  localparam logic [5:0] OP_STR  = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNEQ = 6'd5;
  localparam logic [5:0] OP_ALU  = 6'd6;
  localparam logic [5:0] OP_LDI  = 6'd7;

  logic [5:0] opcode;
  logic [5:0] src_a;
  logic [5:0] src_b;
  logic [5:0] dest;
  logic       use_a;
  logic       use_b;
  logic       writer;

  logic       ex_v, mem_v, wb_v;
  logic [5:0] ex_d, mem_d, wb_d;

  logic       hit_a;
  logic       hit_b;
  logic       hazard;
  logic [1:0] cond;
  logic       unused_ir_bits;

  assign opcode = id_IR[63:58];
  assign src_a  = id_IR[57:52];
  assign src_b  = id_IR[51:46];
  assign dest   = (opcode == OP_LDI) ? id_IR[57:52] : id_IR[17:12];
  assign unused_ir_bits = ^{id_IR[45:18], id_IR[11:0]};

  always_comb begin
    use_a  = 1'b0;
    use_b  = 1'b0;
    writer = 1'b0;
    case (opcode)
      OP_MOV, OP_LD: begin
        use_a  = 1'b1;
        writer = 1'b1;
      end
      OP_STR, OP_BEQ, OP_BNEQ: begin
        use_a = 1'b1;
        use_b = 1'b1;
      end
      OP_ALU: begin
        use_a  = 1'b1;
        use_b  = 1'b1;
        writer = 1'b1;
      end
      OP_LDI:  writer = 1'b1;
      default: ;
    endcase
  end

  // With a write-first register file the WB entry never blocks a read.
  assign hit_a = (ex_v && ex_d == src_a) || (mem_v && mem_d == src_a) ||
                 (!WB_BYPASS && wb_v && wb_d == src_a);
  assign hit_b = (ex_v && ex_d == src_b) || (mem_v && mem_d == src_b) ||
                 (!WB_BYPASS && wb_v && wb_d == src_b);
  assign hazard = id_valid && ((use_a && hit_a) || (use_b && hit_b));

  always_comb begin
    cond = RUN;
    if (mem_busy)             cond = MSTALL;
    else if (ex_branch_taken) cond = FLUSH;
    else if (hazard)          cond = DSTALL;
  end

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    freeze    = 1'b0;
    case (cond)
      MSTALL: begin
        freeze   = 1'b1;
        stall_if = 1'b1;
        stall_id = 1'b1;
      end
      FLUSH: begin
        flush_if = 1'b1;
        flush_id = 1'b1;
      end
      DSTALL: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_state   <= RUN;
      ex_v         <= 1'b0;
      mem_v        <= 1'b0;
      wb_v         <= 1'b0;
      ex_d         <= 6'd0;
      mem_d        <= 6'd0;
      wb_d         <= 6'd0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      ctrl_state <= cond;
      // A frozen back end keeps the scoreboard exactly where it is.
      if (cond != MSTALL) begin
        wb_v  <= mem_v;
        wb_d  <= mem_d;
        mem_v <= ex_v;
        mem_d <= ex_d;
        ex_v  <= (cond == RUN) && id_valid && writer;
        ex_d  <= dest;
      end
      if ((cond == DSTALL || cond == MSTALL) && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (cond == FLUSH && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - randomized scoreboard bench for hazard_stall_controller
// Two instances run in lockstep: 32-bit counters without WB bypass, 4-bit counters with WB bypass.
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] id_IR;
  logic        id_valid;
  logic        ex_branch_taken;
  logic        mem_busy;

  logic        stall_if0, stall_id0, bubble_ex0, flush_if0, flush_id0, freeze0;
  logic [1:0]  state0;
  logic [31:0] sc0, fc0;
  logic        stall_if1, stall_id1, bubble_ex1, flush_if1, flush_id1, freeze1;
  logic [1:0]  state1;
  logic [3:0]  sc1, fc1;

  always #5 clk = ~clk;

  hazard_stall_controller #(.CNT_W(32), .WB_BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .id_IR(id_IR), .id_valid(id_valid),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .stall_if(stall_if0), .stall_id(stall_id0), .bubble_ex(bubble_ex0),
    .flush_if(flush_if0), .flush_id(flush_id0), .freeze(freeze0),
    .ctrl_state(state0), .stall_cycles(sc0), .flush_count(fc0)
  );

  hazard_stall_controller #(.CNT_W(4), .WB_BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .id_IR(id_IR), .id_valid(id_valid),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .stall_if(stall_if1), .stall_id(stall_id1), .bubble_ex(bubble_ex1),
    .flush_if(flush_if1), .flush_id(flush_id1), .freeze(freeze1),
    .ctrl_state(state1), .stall_cycles(sc1), .flush_count(fc1)
  );

  typedef struct {
    logic [5:0]  o0, o1;
    logic [1:0]  s0, s1;
    logic [31:0] sc0, fc0;
    logic [3:0]  sc1, fc1;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: per instance, a list of in-flight destinations (index 0 = youngest), -1 = empty.
  int     inflight[2][3];
  int     m_state[2];
  longint m_stall[2];
  longint m_flush[2];
  longint cap[2] = '{64'hFFFF_FFFF, 64'd15};
  int     stages_seen[2] = '{3, 2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int op, input int a, input int b, input int d);
    logic [63:0] ir;
    ir = {$urandom, $urandom};
    ir[63:58] = 6'(op);
    ir[57:52] = 6'(a);
    ir[51:46] = 6'(b);
    ir[17:12] = 6'(d);
    return ir;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) inflight[k][i] = -1;
      m_state[k] = 0;
      m_stall[k] = 0;
      m_flush[k] = 0;
    end
  endtask

  function automatic bit in_flight(input int k, input int r);
    for (int i = 0; i < stages_seen[k]; i++)
      if (inflight[k][i] == r) return 1'b1;
    return 1'b0;
  endfunction

  // Condition codes follow ctrl_state: 0 run, 1 data stall, 2 memory stall, 3 flush.
  function automatic int model_cond(input int k, input logic [63:0] ir, input bit v, input bit b, input bit m);
    int  op;
    bit  haz;
    op  = int'(ir[63:58]);
    haz = v && (((op inside {1, 2, 3, 4, 5, 6}) && in_flight(k, int'(ir[57:52]))) ||
                ((op inside {3, 4, 5, 6})       && in_flight(k, int'(ir[51:46]))));
    if (m)   return 2;
    if (b)   return 3;
    if (haz) return 1;
    return 0;
  endfunction

  function automatic logic [5:0] model_outs(input int c);
    // {stall_if, stall_id, bubble_ex, flush_if, flush_id, freeze}
    case (c)
      1:       return 6'b111000;
      2:       return 6'b110001;
      3:       return 6'b000110;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic model_step(input int k, input int c, input logic [63:0] ir, input bit v);
    int op;
    op = int'(ir[63:58]);
    if (c != 2) begin
      inflight[k][2] = inflight[k][1];
      inflight[k][1] = inflight[k][0];
      if (c == 0 && v && (op inside {1, 2, 6, 7}))
        inflight[k][0] = (op == 7) ? int'(ir[57:52]) : int'(ir[17:12]);
      else
        inflight[k][0] = -1;
    end
    m_state[k] = c;
    if ((c == 1 || c == 2) && m_stall[k] < cap[k]) m_stall[k]++;
    if (c == 3 && m_flush[k] < cap[k]) m_flush[k]++;
  endtask

  // One cycle: apply inputs just after a rising edge, queue the expected view, advance at the next edge.
  task automatic drive(input bit r, input logic [63:0] ir, input bit v, input bit b, input bit m, output int c0);
    exp_t e;
    int   c[2];
    rst = r;
    id_IR = ir;
    id_valid = v;
    ex_branch_taken = b;
    mem_busy = m;
    if (r) model_reset();
    for (int k = 0; k < 2; k++) c[k] = model_cond(k, ir, v, b, m);
    e.o0  = model_outs(c[0]);
    e.o1  = model_outs(c[1]);
    e.s0  = 2'(m_state[0]);
    e.s1  = 2'(m_state[1]);
    e.sc0 = 32'(m_stall[0]);
    e.fc0 = 32'(m_flush[0]);
    e.sc1 = 4'(m_stall[1]);
    e.fc1 = 4'(m_flush[1]);
    exp_q.push_back(e);
    @(posedge clk);
    if (!r) for (int k = 0; k < 2; k++) model_step(k, c[k], ir, v);
    #1;
    c0 = c[0];
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("outs0", 32'({stall_if0, stall_id0, bubble_ex0, flush_if0, flush_id0, freeze0}), 32'(e.o0));
        chk("outs1", 32'({stall_if1, stall_id1, bubble_ex1, flush_if1, flush_id1, freeze1}), 32'(e.o1));
        chk("state0", 32'(state0), 32'(e.s0));
        chk("state1", 32'(state1), 32'(e.s1));
        chk("stall_cycles0", sc0, e.sc0);
        chk("flush_count0", fc0, e.fc0);
        chk("stall_cycles1", 32'(sc1), 32'(e.sc1));
        chk("flush_count1", 32'(fc1), 32'(e.fc1));
      end
    end
  end

  initial begin : stimulus
    int          c;
    logic [63:0] cur_ir;
    bit          cur_v;
    bit          br;
    bit          need_new;
    bit          m;
    rst = 1'b1;
    id_IR = '0;
    id_valid = 1'b0;
    ex_branch_taken = 1'b0;
    mem_busy = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    drive(1'b1, '0, 1'b0, 1'b0, 1'b0, c);
    chk("reset_outs", 32'({stall_if0, stall_id0, bubble_ex0, flush_if0, flush_id0, freeze0, state0}), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, c);

    // ALU r5 then a dependent: three stalls without bypass, two with it.
    drive(1'b0, mk(6, 0, 0, 5), 1'b1, 1'b0, 1'b0, c);
    for (int i = 0; i < 4; i++) drive(1'b0, mk(6, 5, 0, 6), 1'b1, 1'b0, 1'b0, c);
    chk("raw_stalls_nobypass", sc0, 32'd3);
    chk("raw_stalls_bypass", 32'(sc1), 32'd2);

    // LDI dest comes from [57:52], not [17:12].
    drive(1'b0, mk(7, 9, 0, 4), 1'b1, 1'b0, 1'b0, c);
    drive(1'b0, mk(1, 4, 0, 10), 1'b1, 1'b0, 1'b0, c);
    chk("ldi_no_false_stall", 32'(stall_id0), 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, mk(1, 9, 0, 11), 1'b1, 1'b0, 1'b0, c);

    // Branch with hazard pending, memory freeze, branch masked by memory busy.
    drive(1'b0, mk(6, 0, 0, 7), 1'b1, 1'b0, 1'b0, c);
    drive(1'b0, mk(6, 7, 7, 8), 1'b1, 1'b1, 1'b0, c);
    drive(1'b0, mk(6, 0, 0, 3), 1'b1, 1'b0, 1'b0, c);
    for (int i = 0; i < 4; i++) drive(1'b0, mk(6, 3, 1, 2), 1'b1, 1'b0, 1'b1, c);
    for (int i = 0; i < 4; i++) drive(1'b0, mk(6, 3, 1, 2), 1'b1, 1'b0, 1'b0, c);
    for (int i = 0; i < 2; i++) drive(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b1, 1'b1, c);
    drive(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b1, 1'b0, c);
    drive(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0, 1'b0, c);

    // Reset in the middle of a data stall.
    drive(1'b0, mk(6, 0, 0, 5), 1'b1, 1'b0, 1'b0, c);
    drive(1'b0, mk(6, 5, 0, 6), 1'b1, 1'b0, 1'b0, c);
    drive(1'b1, mk(6, 5, 0, 6), 1'b1, 1'b0, 1'b0, c);
    chk("rst_mid_stall_cnt", sc0, 32'd0);
    drive(1'b0, mk(6, 5, 0, 6), 1'b1, 1'b0, 1'b0, c);

    // Random traffic; an instruction stays in ID until it issues or is flushed.
    need_new = 1'b1;
    br = 1'b0;
    cur_ir = '0;
    cur_v = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (need_new) begin
        cur_ir = mk(int'($urandom_range(0, 9)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        cur_v = ($urandom_range(0, 9) != 0);
      end
      m = ($urandom_range(0, 99) < 15);
      if (!br) br = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 199) == 0) begin
        drive(1'b1, cur_ir, cur_v, br, m, c);
        br = 1'b0;
        need_new = 1'b0;
      end else begin
        drive(1'b0, cur_ir, cur_v, br, m, c);
        need_new = (c == 0 || c == 3);
        if (c == 3) br = 1'b0;
      end
    end

    // Enough memory stalls without reset to drive the 4-bit counter to its ceiling.
    for (int i = 0; i < 20; i++) drive(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0, 1'b1, c);
    chk("stall_saturate_4b", 32'(sc1), 32'd15);
    drive(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0, 1'b0, c);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage 64-bit pipeline (IF, ID, EX, MEM, WB).
- Keeps a shadow scoreboard of the register-writing instructions in flight in EX, MEM and WB, and stalls ID on read-after-write hazards.
- Squashes IF/ID on a taken branch and freezes the back end while data memory is busy.
- Decodes the same opcode set the WB decoder uses. Also provides performance counters.

Parameters:
- CNT_W, 32, width of the stall_cycles and flush_count performance counters.
- WB_BYPASS, 0: 1 = register file is write-first, so a match against the WB stage is not a hazard.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- id_IR  input  64  instruction currently in ID.
- id_valid  input  1  id_IR holds a real instruction.
- ex_branch_taken  input  1  BEQ/BNEQ in EX resolved taken; held by EX while frozen.
- mem_busy  input  1  data memory not ready; MEM must hold.
- stall_if  output  1  hold PC and IF/ID register.
- stall_id  output  1  hold ID stage.
- bubble_ex  output  1  load NOP into ID/EX this edge.
- flush_if  output  1  replace IF/ID contents with NOP.
- flush_id  output  1  replace ID/EX contents with NOP.
- freeze  output  1  hold EX/MEM/WB registers.
- ctrl_state  output  2  registered condition of the previous cycle: 0 RUN, 1 DSTALL, 2 MSTALL, 3 FLUSH.
- stall_cycles  output  CNT_W  count of DSTALL plus MSTALL cycles.
- flush_count  output  CNT_W  count of FLUSH cycles.

Behaviour:
- Opcode field is [63:58]: NOP 0, MOV 1, LD 2, STR 3, BEQ 4, BNEQ 5, ALU 6, LDI 7. Any other code is treated as NOP.
- Source registers:
  - srcA = [57:52], used by MOV, LD, STR, BEQ, BNEQ, ALU.
  - srcB = [51:46], used by STR, BEQ, BNEQ, ALU.
  - LDI and NOP read no registers.
- Destination register:
  - Writers are MOV, LD, ALU and LDI.
  - dest = [57:52] for LDI, [17:12] for the others.
- Scoreboard: three entries, ex/mem/wb, each {valid, dest[5:0]}.
- Hazard: id_valid is high and a used source equals the dest of a valid ex, mem or wb entry. The wb entry is ignored when WB_BYPASS=1.
- Outputs are combinational and priority-ordered:
  1. mem_busy: freeze, stall_if, stall_id = 1; all others 0. Scoreboard holds. Condition MSTALL.
  2. ex_branch_taken: flush_if, flush_id = 1. Scoreboard shifts with ex <= invalid. Condition FLUSH.
  3. Hazard: stall_if, stall_id, bubble_ex = 1. Scoreboard shifts with ex <= invalid. Condition DSTALL.
  4. Otherwise all outputs 0 and ID issues. Scoreboard shifts with ex <= {id_valid and writer, dest}. Condition RUN.
- Shift means wb <= mem, mem <= ex.
- A mem_busy that coincides with a branch or hazard masks both. The branch is taken on the first cycle mem_busy is low.
- ctrl_state, stall_cycles and flush_count update on the clock edge from that cycle's condition. Counters saturate at all-ones and never wrap.
- Reset (asynchronous, any time, including mid-stall or mid-flush):
  - All scoreboard entries invalid.
  - ctrl_state = RUN.
  - Both counters = 0.
  - Combinational outputs follow the cleared state, so they are all 0 while mem_busy=0, ex_branch_taken=0 and no hazard exists.
- The same register in srcA and srcB counts as one hazard. A writer whose dest equals its own source is not a hazard with itself.

Test Plan:
- ALU writing r5 issues; next cycle ALU reads r5 as srcA, WB_BYPASS=0 -> stall_id=1 for exactly 3 cycles, issues on the 4th; stall_cycles=3, ctrl_state=DSTALL for those cycles. Repeat with WB_BYPASS=1 -> 2 cycles.
- LDI with [57:52]=9, [17:12]=4, then MOV reading srcA=4 -> no stall. Then MOV reading r9 -> stalls.
- ex_branch_taken pulse with hazard pending in ID -> flush_if=flush_id=1, bubble_ex=0; flush_count=1; next cycle ctrl_state=FLUSH.
- mem_busy held 4 cycles with ALU r3 in ex -> freeze=1 for 4 cycles, scoreboard unchanged; a dependent in ID issues 3 cycles after release; stall_cycles=4+3.
- ex_branch_taken and mem_busy asserted together for 2 cycles, then mem_busy drops -> MSTALL ×2, then FLUSH ×1.
- rst pulsed mid-DSTALL, counters nonzero -> immediately all outputs 0, counters 0, ctrl_state=RUN, the previously dependent instruction issues the cycle after release. Preload stall_cycles near all-ones (CNT_W=4) -> saturates at 15.
